// File: rtl/pong_ball_engine_if.sv
// Pin bundle between the pong game-state engine and its surroundings: game tick,
// start request and paddle positions in; ball position, scores and status out.
`timescale 1ns/1ps
interface pong_ball_engine_if;
  logic       gClk;
  logic       start;
  logic [9:0] left_y;
  logic [9:0] right_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point_l;
  logic       point_r;
  logic       playing;
  logic       game_over;

  modport master (
    output gClk, start, left_y, right_y,
    input  ball_x, ball_y, score_l, score_r, point_l, point_r, playing, game_over
  );

  modport slave (
    input  gClk, start, left_y, right_y,
    output ball_x, ball_y, score_l, score_r, point_l, point_r, playing, game_over
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong game-state engine: once per game tick it moves the ball, bounces it off walls
// and paddles, detects misses, keeps score and sequences serve / play / game over.
`timescale 1ns/1ps
module pong_ball_engine #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned L_PADDLE_X  = 16,
  parameter int unsigned R_PADDLE_X  = 616,
  parameter int unsigned SPEED       = 4,
  parameter int unsigned SERVE_TICKS = 50,
  parameter int unsigned SCORE_MAX   = 9
) (
  input  logic              clk,
  input  logic              rstn,
  pong_ball_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  localparam int unsigned CNT_W = $clog2(SERVE_TICKS + 1);

  localparam logic [9:0]       CENTRE_X   = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]       CENTRE_Y   = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]       SPD10      = 10'(SPEED);
  localparam logic [9:0]       Y_MAX10    = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0]       R_HIT_X    = 10'(R_PADDLE_X - BALL_SIZE);
  localparam logic [9:0]       L_FACE10   = 10'(L_PADDLE_X + PADDLE_W);
  localparam logic [10:0]      SPD        = 11'(SPEED);
  localparam logic [10:0]      BSZ        = 11'(BALL_SIZE);
  localparam logic [10:0]      PH         = 11'(PADDLE_H);
  localparam logic [10:0]      Y_MAX      = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0]      X_LIM      = 11'(H_RES);
  localparam logic [10:0]      R_FACE     = 11'(R_PADDLE_X);
  localparam logic [10:0]      L_FACE     = 11'(L_PADDLE_X + PADDLE_W);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       SCORE_END  = 4'(SCORE_MAX);

  state_t           state_q, state_d;
  logic             gclk_d_q, gclk_d_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dir_right_q, dir_right_d;
  logic             dir_down_q, dir_down_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic             point_l_q, point_l_d;
  logic             point_r_q, point_r_d;
  logic             playing_q, playing_d;
  logic             game_over_q, game_over_d;

  logic             tick;
  logic             miss_l, miss_r;
  logic [10:0]      x11, y11, ly11, ry11;
  logic [10:0]      x_end, x_step, y_sum;
  logic [9:0]       x_dec, y_dec;
  logic             overlap_l, overlap_r;
  logic             cross_l, cross_r;

  // All geometry is done on 11-bit zero-extended copies so no sum can wrap.
  assign tick      = bus.gClk & ~gclk_d_q;
  assign x11       = {1'b0, ball_x_q};
  assign y11       = {1'b0, ball_y_q};
  assign ly11      = {1'b0, bus.left_y};
  assign ry11      = {1'b0, bus.right_y};
  assign x_end     = x11 + BSZ;
  assign x_step    = x11 + SPD;
  assign y_sum     = y11 + SPD;
  assign x_dec     = ball_x_q - SPD10;
  assign y_dec     = ball_y_q - SPD10;
  assign overlap_r = (y11 + BSZ > ry11) && (y11 < ry11 + PH);
  assign overlap_l = (y11 + BSZ > ly11) && (y11 < ly11 + PH);
  assign cross_r   = (x_end <= R_FACE) && (x_end + SPD >= R_FACE);
  assign cross_l   = (x11 >= L_FACE) && (x11 <= L_FACE + SPD);

  always_comb begin
    state_d     = state_q;
    gclk_d_d    = bus.gClk;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_right_d = dir_right_q;
    dir_down_d  = dir_down_q;
    serve_cnt_d = serve_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;
    miss_l      = 1'b0;
    miss_r      = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        // A start here swallows any coincident tick, since ticks do nothing in these states.
        if (bus.start) begin
          state_d     = SERVE;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          dir_right_d = 1'b1;
          dir_down_d  = 1'b1;
          ball_x_d    = CENTRE_X;
          ball_y_d    = CENTRE_Y;
          serve_cnt_d = '0;
        end
      end
      SERVE: begin
        if (tick) begin
          if (serve_cnt_q == SERVE_LAST) state_d = PLAY;
          else                           serve_cnt_d = serve_cnt_q + CNT_ONE;
        end
      end
      PLAY: begin
        if (tick) begin
          if (dir_down_q) begin
            if (y_sum >= Y_MAX) begin
              ball_y_d   = Y_MAX10;
              dir_down_d = 1'b0;
            end else begin
              ball_y_d = y_sum[9:0];
            end
          end else begin
            if (y11 <= SPD) begin
              ball_y_d   = 10'd0;
              dir_down_d = 1'b1;
            end else begin
              ball_y_d = y_dec;
            end
          end

          if (dir_right_q) begin
            if (cross_r && overlap_r) begin
              ball_x_d    = R_HIT_X;
              dir_right_d = 1'b0;
            end else begin
              ball_x_d = x_step[9:0];
              miss_l   = (x_step + BSZ >= X_LIM);
            end
          end else begin
            if (cross_l && overlap_l) begin
              ball_x_d    = L_FACE10;
              dir_right_d = 1'b1;
            end else if (x11 <= SPD) begin
              miss_r = 1'b1;
            end else begin
              ball_x_d = x_dec;
            end
          end

          // The next serve heads toward whoever just conceded; vertical direction carries over.
          if (miss_l || miss_r) begin
            ball_x_d    = CENTRE_X;
            ball_y_d    = CENTRE_Y;
            serve_cnt_d = '0;
            dir_right_d = miss_l;
            state_d     = SERVE;
          end
          if (miss_l) begin
            score_l_d = score_l_q + 4'd1;
            point_l_d = 1'b1;
            if (score_l_q + 4'd1 == SCORE_END) state_d = OVER;
          end
          if (miss_r) begin
            score_r_d = score_r_q + 4'd1;
            point_r_d = 1'b1;
            if (score_r_q + 4'd1 == SCORE_END) state_d = OVER;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    playing_d   = (state_d == PLAY);
    game_over_d = (state_d == OVER);
  end

  // gclk_d_q resets high so a tick level already present at reset release is not a tick.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      gclk_d_q    <= 1'b1;
      ball_x_q    <= CENTRE_X;
      ball_y_q    <= CENTRE_Y;
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
      serve_cnt_q <= '0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gclk_d_q    <= gclk_d_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_right_q <= dir_right_d;
      dir_down_q  <= dir_down_d;
      serve_cnt_q <= serve_cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      point_l_q   <= point_l_d;
      point_r_q   <= point_r_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.ball_x    = ball_x_q;
  assign bus.ball_y    = ball_y_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.point_l   = point_l_q;
  assign bus.point_r   = point_r_q;
  assign bus.playing   = playing_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: directed game sequence with randomized paddle positions,
// every tick compared against a plain-integer model of the game rules.
`timescale 1ns/1ps
module tb_pong_ball_engine;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_OVER  = 3;

  logic clk;
  logic rstn;
  pong_ball_engine_if bus ();

  pong_ball_engine dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tickNo = 0;

  int mState, mx, my, mdx, mdy, mSl, mSr, mServe;
  int mPl, mPr;
  int seenPl, seenPr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = S_IDLE; mx = 316; my = 236; mdx = 1; mdy = 1;
    mSl = 0; mSr = 0; mServe = 0; mPl = 0; mPr = 0;
  endtask

  task automatic modelStart();
    mPl = 0; mPr = 0;
    if (mState == S_IDLE || mState == S_OVER) begin
      mState = S_SERVE; mSl = 0; mSr = 0; mdx = 1; mdy = 1;
      mx = 316; my = 236; mServe = 0;
    end
  endtask

  task automatic modelTick(input int ly, input int ry);
    int py;
    bit missL, missR;
    mPl = 0; mPr = 0; missL = 0; missR = 0;
    if (mState == S_SERVE) begin
      mServe++;
      if (mServe == 50) mState = S_PLAY;
    end else if (mState == S_PLAY) begin
      py = my;
      if (mdy > 0) begin
        if (my + 4 >= 472) begin my = 472; mdy = -1; end
        else my += 4;
      end else begin
        if (my <= 4) begin my = 0; mdy = 1; end
        else my -= 4;
      end
      if (mdx > 0) begin
        if (mx + 8 <= 616 && mx + 12 >= 616 && py + 8 > ry && py < ry + 64) begin
          mx = 608; mdx = -1;
        end else begin
          mx += 4;
          missL = (mx + 8 >= 640);
        end
      end else begin
        if (mx >= 24 && mx - 4 <= 24 && py + 8 > ly && py < ly + 64) begin
          mx = 24; mdx = 1;
        end else if (mx <= 4) missR = 1;
        else mx -= 4;
      end
      if (missL) begin mSl++; mPl = 1; mdx = 1; end
      if (missR) begin mSr++; mPr = 1; mdx = -1; end
      if (missL || missR) begin
        mx = 316; my = 236; mServe = 0;
        mState = (mSl == 9 || mSr == 9) ? S_OVER : S_SERVE;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput($sformatf("%s_ball_x", tag), 32'(bus.ball_x), 32'(mx));
    checkOutput($sformatf("%s_ball_y", tag), 32'(bus.ball_y), 32'(my));
    checkOutput($sformatf("%s_score_l", tag), 32'(bus.score_l), 32'(mSl));
    checkOutput($sformatf("%s_score_r", tag), 32'(bus.score_r), 32'(mSr));
    checkOutput($sformatf("%s_playing", tag), 32'(bus.playing), 32'(mState == S_PLAY));
    checkOutput($sformatf("%s_game_over", tag), 32'(bus.game_over), 32'(mState == S_OVER));
    checkOutput($sformatf("%s_point_l_clks", tag), 32'(seenPl), 32'(mPl));
    checkOutput($sformatf("%s_point_r_clks", tag), 32'(seenPr), 32'(mPr));
  endtask

  // One game tick (optionally with a coincident start); point pulses are counted per clk.
  task automatic applyStimulus(input int ly, input int ry, input bit withStart);
    bus.left_y  = 10'(ly);
    bus.right_y = 10'(ry);
    seenPl = 0; seenPr = 0;
    @(negedge clk);
    bus.gClk = 1'b1;
    if (withStart) bus.start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
      seenPl += int'(bus.point_l);
      seenPr += int'(bus.point_r);
    end
    bus.gClk = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seenPl += int'(bus.point_l);
      seenPr += int'(bus.point_r);
    end
    if (withStart) modelStart();
    else modelTick(ly, ry);
    tickNo++;
    checkAll($sformatf("t%0d", tickNo));
  endtask

  task automatic pulseStart();
    seenPl = 0; seenPr = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    modelStart();
    checkAll("start");
  endtask

  function automatic int followY(input int y);
    return (y > 28) ? y - 28 : 0;
  endfunction

  initial begin
    int budget;
    bus.gClk = 1'b1; bus.start = 1'b0; bus.left_y = '0; bus.right_y = '0;
    rstn = 1'b0;
    modelReset();
    seenPl = 0; seenPr = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkAll("reset");

    bus.gClk = 1'b0;
    applyStimulus(100, 400, 1'b0);
    pulseStart();

    $display("[TB] serve and first rally with right paddle at 400");
    for (int i = 0; i < 73 + 50; i++)
      applyStimulus($urandom_range(0, 416), 400, 1'b0);

    $display("[TB] random paddle phase");
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 416), $urandom_range(0, 416), 1'b0);

    $display("[TB] steering left to win");
    budget = 3000;
    while (mState != S_OVER && budget > 0) begin
      applyStimulus(followY(my), (my < 240) ? 416 : 0, 1'b0);
      budget--;
    end
    checkOutput("reached_game_over", 32'(bus.game_over), 32'd1);
    checkOutput("winner_score_l", 32'(bus.score_l), 32'd9);

    applyStimulus(200, 200, 1'b0);
    applyStimulus(200, 200, 1'b1);
    checkOutput("restart_score_l", 32'(bus.score_l), 32'd0);

    for (int i = 0; i < 56; i++)
      applyStimulus($urandom_range(0, 416), $urandom_range(0, 416), 1'b0);

    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    seenPl = 0; seenPr = 0;
    checkAll("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checkAll("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
